id_imm_stage: RTL and testbench
===============================

Name: id_imm_stage

Overview:
- IF/ID pipeline register for the 31-instruction MIPS core; sits directly upstream of the immediate extender.
- Latches the fetched instruction and PC, then decodes opcode/funct into registered extender controls: imm16, imm_sext, imm_sel and shamt.
- Supports stall (hold) and flush (bubble) from the hazard unit.
- One-cycle latency from IF to ID outputs.

Parameters:
- PC_W, 32, width of the program counter carried alongside the instruction
- NOP_INSTR, 32'h0000_0000, instruction word loaded on reset, flush or bubble (sll $0,$0,0)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  hold all ID registers this cycle
- flush  in  1  replace ID contents with a bubble this cycle
- if_valid  in  1  if_instr/if_pc carry a real instruction
- if_instr  in  32  fetched instruction
- if_pc  in  PC_W  PC of if_instr
- id_valid  out  1  ID slot holds a real instruction
- id_instr  out  32  registered instruction
- id_pc  out  PC_W  registered PC
- imm16  out  16  instr[15:0]; feeds the extender data input
- imm_sext  out  1  1 = sign-extend, 0 = zero-extend; feeds the extender sext input
- imm_sel  out  1  ALU operand B comes from the extended immediate
- shamt  out  5  instr[10:6] for sll/srl/sra, else 0
- illegal  out  1  id_valid and the opcode/funct pair is not in the supported set

Behaviour:
- Register update priority each rising edge: rst > flush > stall > load.
- rst: id_valid=0, id_instr=NOP_INSTR, id_pc=0, imm16=0, imm_sext=0, imm_sel=0, shamt=0, illegal=0.
- flush: same values as rst. flush beats stall when both are asserted.
- stall (no rst/flush): every output holds its value.
- load with if_valid=1:
  - id_instr<=if_instr, id_pc<=if_pc, id_valid<=1.
  - Decode fields are computed from if_instr and registered in the same edge, so no combinational path exists from id_instr to the controls.
- load with if_valid=0: bubble (id_valid=0, id_instr=NOP_INSTR, controls 0). id_pc <= if_pc.
- Sign-extend opcodes, imm_sext=1:
  - addi 08, addiu 09, slti 0A, sltiu 0B, lw 23, sw 2B: imm_sel=1.
  - beq 04, bne 05: imm_sel=0 (immediate is the branch offset only).
- Zero-extend opcodes, imm_sext=0, imm_sel=1: andi 0C, ori 0D, xori 0E, lui 0F.
- j 02, jal 03: imm_sext=0, imm_sel=0.
- R-type, opcode 00:
  - Supported funct values: 20,21,22,23,24,25,26,27,2A,2B,00,02,03,04,06,07,08.
  - shamt=instr[10:6] only for funct 00/02/03; otherwise 0.
  - imm_sel=0.
- imm16 is always instr[15:0] of a loaded instruction, regardless of opcode.
- illegal=1 for any other opcode or unsupported funct. For an illegal instruction: imm_sel=0, imm_sext=0, id_valid stays 1.
- A bubble never asserts illegal.
- Reset mid-stall: rst wins and clears the stage. After rst deasserts, the first load edge captures the current if_* inputs.

Optional Feature:
- Macro: ID_BR_OFFSET18_EN.
- Defined: adds output br_off18 [17:0] = {imm16,2'b00}, registered with the same rst/flush/stall/load rules.
  - Valid only for beq/bne; 0 otherwise.
  - Feeds an 18-bit sign-extending extender instance.
- Undefined: port and register are absent. No other behaviour changes.

Decomposition:
- Package cpu31_pkg holds:
  - opcode localparams: OP_RTYPE, OP_ADDI … OP_LUI, OP_J, OP_JAL
  - funct localparams: FN_ADD … FN_JR
  - the NOP word constant
- One combinational sub-module, imm_decode: inputs opcode and funct; outputs imm_sext, imm_sel, is_shift, illegal.
- id_imm_stage instantiates imm_decode once and owns all registers.

Test Plan:
- Reset: rst=1 for 2 cycles with if_valid=1, if_instr=32'h2008FFFF → all outputs 0, id_instr=0.
- Load addi: if_instr=32'h2008FFFF, if_pc=32'h0040_0000 → next cycle id_valid=1, imm16=16'hFFFF, imm_sext=1, imm_sel=1, illegal=0.
- Load ori then stall: 32'h3508_8000 loaded, then stall=1 for 3 cycles while if_instr changes → imm16=16'h8000, imm_sext=0, imm_sel=1, all outputs held 3 cycles.
- Flush over stall: stall=1 and flush=1 together with a valid beq 32'h1109_0004 in ID → next cycle id_valid=0, id_instr=0, controls 0.
- Shift and illegal:
  - sra 32'h0008_4883 → shamt=5'd2, imm_sel=0.
  - opcode 3F word 32'hFC00_0000 → illegal=1, id_valid=1.
  - if_valid=0 → illegal=0.
- With ID_BR_OFFSET18_EN defined: bne 32'h1509_FFFE → br_off18=18'h3FFF8. addi → br_off18=0.

Source files
------------

// File: rtl/cpu31_pkg.sv
// Shared encodings for the 31-instruction MIPS core: opcode/funct values,
// the NOP word and the registered immediate-extender control bundle.
package cpu31_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [15:0] imm16;
        logic        imm_sext;
        logic        imm_sel;
        logic [4:0]  shamt;
        logic        illegal;
    } id_ctrl_t;

    localparam id_ctrl_t CTRL_CLEAR = '0;

    function automatic logic is_branch(input logic [5:0] opcode);
        return (opcode == OP_BEQ) || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/id_imm_stage_if.sv
// IF -> ID handshake and ID -> extender control bundle.
// Optional macro ID_BR_OFFSET18_EN adds the br_off18 field.
interface id_imm_stage_if #(
    parameter int PC_W = 32
);
    logic            stall;
    logic            flush;
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;

    logic            id_valid;
    logic [31:0]     id_instr;
    logic [PC_W-1:0] id_pc;
    logic [15:0]     imm16;
    logic            imm_sext;
    logic            imm_sel;
    logic [4:0]      shamt;
    logic            illegal;
`ifdef ID_BR_OFFSET18_EN
    logic [17:0]     br_off18;

    modport master (
        output stall, flush, if_valid, if_instr, if_pc,
        input  id_valid, id_instr, id_pc, imm16, imm_sext, imm_sel, shamt, illegal, br_off18
    );
    modport slave (
        input  stall, flush, if_valid, if_instr, if_pc,
        output id_valid, id_instr, id_pc, imm16, imm_sext, imm_sel, shamt, illegal, br_off18
    );
`else
    modport master (
        output stall, flush, if_valid, if_instr, if_pc,
        input  id_valid, id_instr, id_pc, imm16, imm_sext, imm_sel, shamt, illegal
    );
    modport slave (
        input  stall, flush, if_valid, if_instr, if_pc,
        output id_valid, id_instr, id_pc, imm16, imm_sext, imm_sel, shamt, illegal
    );
`endif
endinterface

// File: rtl/imm_decode.sv
// Combinational opcode/funct decode into immediate-extender controls.
// Unsupported encodings raise illegal_o with both extender controls low.
module imm_decode
    import cpu31_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic       imm_sext_o,
    output logic       imm_sel_o,
    output logic       is_shift_o,
    output logic       illegal_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        imm_sext_o = 1'b0;
        imm_sel_o  = 1'b0;
        is_shift_o = 1'b0;
        illegal_o  = 1'b0;
        case (opcode_i)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                imm_sext_o = 1'b1;
                imm_sel_o  = 1'b1;
            end
            // Branch offsets are sign-extended but never feed ALU operand B.
            OP_BEQ, OP_BNE: imm_sext_o = 1'b1;
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: imm_sel_o = 1'b1;
            OP_J, OP_JAL: ;
            OP_RTYPE: begin
                case (funct_i)
                    FN_SLL, FN_SRL, FN_SRA: is_shift_o = 1'b1;
                    FN_SLLV, FN_SRLV, FN_SRAV, FN_JR,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: ;
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_imm_stage.sv
// IF/ID pipeline register with registered immediate-extender controls.
// Optional macro ID_BR_OFFSET18_EN adds a registered 18-bit branch offset.
module id_imm_stage
    import cpu31_pkg::*;
#(
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic             clk,
    input  logic             rst,
    id_imm_stage_if.slave    bus
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    id_ctrl_t        ctrl_q, ctrl_d;

    logic dec_sext, dec_sel, dec_shift, dec_illegal;

    // Decode is taken from the IF word so the controls register alongside it.
    imm_decode u_imm_decode (
        .opcode_i   (bus.if_instr[31:26]),
        .funct_i    (bus.if_instr[5:0]),
        .imm_sext_o (dec_sext),
        .imm_sel_o  (dec_sel),
        .is_shift_o (dec_shift),
        .illegal_o  (dec_illegal)
    );

`ifdef ID_BR_OFFSET18_EN
    logic [17:0] br_off18_q, br_off18_d;
`endif

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        ctrl_d  = ctrl_q;
`ifdef ID_BR_OFFSET18_EN
        br_off18_d = br_off18_q;
`endif
        if (bus.flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = '0;
            ctrl_d  = CTRL_CLEAR;
`ifdef ID_BR_OFFSET18_EN
            br_off18_d = '0;
`endif
        end else if (!bus.stall) begin
            pc_d = bus.if_pc;
            if (bus.if_valid) begin
                valid_d          = 1'b1;
                instr_d          = bus.if_instr;
                ctrl_d.imm16     = bus.if_instr[15:0];
                ctrl_d.imm_sext  = dec_sext;
                ctrl_d.imm_sel   = dec_sel;
                ctrl_d.shamt     = dec_shift ? bus.if_instr[10:6] : 5'd0;
                ctrl_d.illegal   = dec_illegal;
`ifdef ID_BR_OFFSET18_EN
                br_off18_d = is_branch(bus.if_instr[31:26]) ? {bus.if_instr[15:0], 2'b00} : 18'd0;
`endif
            end else begin
                // Bubble keeps the PC for debug visibility but clears everything else.
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                ctrl_d  = CTRL_CLEAR;
`ifdef ID_BR_OFFSET18_EN
                br_off18_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            ctrl_q  <= CTRL_CLEAR;
`ifdef ID_BR_OFFSET18_EN
            br_off18_q <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
`ifdef ID_BR_OFFSET18_EN
            br_off18_q <= br_off18_d;
`endif
        end
    end

    assign bus.id_valid = valid_q;
    assign bus.id_instr = instr_q;
    assign bus.id_pc    = pc_q;
    assign bus.imm16    = ctrl_q.imm16;
    assign bus.imm_sext = ctrl_q.imm_sext;
    assign bus.imm_sel  = ctrl_q.imm_sel;
    assign bus.shamt    = ctrl_q.shamt;
    assign bus.illegal  = ctrl_q.illegal;
`ifdef ID_BR_OFFSET18_EN
    assign bus.br_off18 = br_off18_q;
`endif

endmodule

// File: tb/tb_id_imm_stage.sv
// Table-driven bench for id_imm_stage: each vector is applied for one edge
// and every ID output is compared just after that edge.
module tb_id_imm_stage;

    logic clk = 1'b0;
    logic rst;

    id_imm_stage_if #(.PC_W(32)) bus ();

    id_imm_stage #(.PC_W(32), .NOP_INSTR(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        if_valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [15:0] e_imm16;
        logic        e_sext;
        logic        e_sel;
        logic [4:0]  e_shamt;
        logic        e_ill;
        logic [17:0] e_br;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        rst          = v.rst;
        bus.stall    = v.stall;
        bus.flush    = v.flush;
        bus.if_valid = v.if_valid;
        bus.if_instr = v.instr;
        bus.if_pc    = v.pc;
        @(posedge clk);
        #1;
        check({tag, ".id_valid"}, {31'd0, bus.id_valid}, {31'd0, v.e_valid});
        check({tag, ".id_instr"}, bus.id_instr, v.e_instr);
        check({tag, ".id_pc"},    bus.id_pc,    v.e_pc);
        check({tag, ".imm16"},    {16'd0, bus.imm16}, {16'd0, v.e_imm16});
        check({tag, ".imm_sext"}, {31'd0, bus.imm_sext}, {31'd0, v.e_sext});
        check({tag, ".imm_sel"},  {31'd0, bus.imm_sel},  {31'd0, v.e_sel});
        check({tag, ".shamt"},    {27'd0, bus.shamt},    {27'd0, v.e_shamt});
        check({tag, ".illegal"},  {31'd0, bus.illegal},  {31'd0, v.e_ill});
`ifdef ID_BR_OFFSET18_EN
        check({tag, ".br_off18"}, {14'd0, bus.br_off18}, {14'd0, v.e_br});
`endif
    endtask

    initial begin
        //            rst  stl  fl   iv   instr          pc             ev   e_instr        e_pc           imm16     sx   sel  sh    ill  br
        vq.push_back('{1'b1,1'b0,1'b0,1'b1,32'h2008FFFF,32'h0040_0000,1'b0,32'h00000000,32'h00000000,16'h0000,1'b0,1'b0,5'd0,1'b0,18'h0});
        vq.push_back('{1'b1,1'b0,1'b0,1'b1,32'h2008FFFF,32'h0040_0000,1'b0,32'h00000000,32'h00000000,16'h0000,1'b0,1'b0,5'd0,1'b0,18'h0});
        // addi, ori, then three stall cycles with changing IF inputs
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h2008FFFF,32'h0040_0000,1'b1,32'h2008FFFF,32'h0040_0000,16'hFFFF,1'b1,1'b1,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h35088000,32'h0040_0004,1'b1,32'h35088000,32'h0040_0004,16'h8000,1'b0,1'b1,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b1,1'b0,1'b1,32'h00084883,32'h0040_0099,1'b1,32'h35088000,32'h0040_0004,16'h8000,1'b0,1'b1,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b1,1'b0,1'b0,32'hFC000000,32'h0040_009C,1'b1,32'h35088000,32'h0040_0004,16'h8000,1'b0,1'b1,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b1,1'b0,1'b1,32'h1509FFFE,32'h0040_00A0,1'b1,32'h35088000,32'h0040_0004,16'h8000,1'b0,1'b1,5'd0,1'b0,18'h0});
        // beq, then flush beats stall
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h11090004,32'h0040_0008,1'b1,32'h11090004,32'h0040_0008,16'h0004,1'b1,1'b0,5'd0,1'b0,18'h00010});
        vq.push_back('{1'b0,1'b1,1'b1,1'b1,32'h2008FFFF,32'h0040_000C,1'b0,32'h00000000,32'h00000000,16'h0000,1'b0,1'b0,5'd0,1'b0,18'h0});
        // sra, sllv (shamt field nonzero but not a shift), illegal opcode, illegal funct
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h00084883,32'h0040_000C,1'b1,32'h00084883,32'h0040_000C,16'h4883,1'b0,1'b0,5'd2,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h000848C4,32'h0040_0010,1'b1,32'h000848C4,32'h0040_0010,16'h48C4,1'b0,1'b0,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'hFC000000,32'h0040_0014,1'b1,32'hFC000000,32'h0040_0014,16'h0000,1'b0,1'b0,5'd0,1'b1,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h00000001,32'h0040_0018,1'b1,32'h00000001,32'h0040_0018,16'h0001,1'b0,1'b0,5'd0,1'b1,18'h0});
        // bubble: PC still captured, illegal never set
        vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'hFC000000,32'h0040_001C,1'b0,32'h00000000,32'h0040_001C,16'h0000,1'b0,1'b0,5'd0,1'b0,18'h0});
        // lui, lw, j, jr, sltiu, xori, bne
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h3C011234,32'h0040_0020,1'b1,32'h3C011234,32'h0040_0020,16'h1234,1'b0,1'b1,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h8C82FFF0,32'h0040_0024,1'b1,32'h8C82FFF0,32'h0040_0024,16'hFFF0,1'b1,1'b1,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h08100000,32'h0040_0028,1'b1,32'h08100000,32'h0040_0028,16'h0000,1'b0,1'b0,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h03E00008,32'h0040_002C,1'b1,32'h03E00008,32'h0040_002C,16'h0008,1'b0,1'b0,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h2C21FFFF,32'h0040_0030,1'b1,32'h2C21FFFF,32'h0040_0030,16'hFFFF,1'b1,1'b1,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h3821ABCD,32'h0040_0034,1'b1,32'h3821ABCD,32'h0040_0034,16'hABCD,1'b0,1'b1,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h1509FFFE,32'h0040_0038,1'b1,32'h1509FFFE,32'h0040_0038,16'hFFFE,1'b1,1'b0,5'd0,1'b0,18'h3FFF8});
        // flush alone, then addi clears the branch offset, then sll with shamt 3
        vq.push_back('{1'b0,1'b0,1'b1,1'b1,32'h2008FFFF,32'h0040_003C,1'b0,32'h00000000,32'h00000000,16'h0000,1'b0,1'b0,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h2008FFFF,32'h0040_0040,1'b1,32'h2008FFFF,32'h0040_0040,16'hFFFF,1'b1,1'b1,5'd0,1'b0,18'h0});
        vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h000848C0,32'h0040_0044,1'b1,32'h000848C0,32'h0040_0044,16'h48C0,1'b0,1'b0,5'd3,1'b0,18'h0});

        for (int i = 0; i < vq.size(); i++) begin
            apply($sformatf("v%0d", i), vq[i]);
        end

        // Reset arriving during a stall clears the stage; the next edge loads live IF inputs.
        apply("rs_load",  '{1'b0,1'b0,1'b0,1'b1,32'h11090004,32'h0040_0100,1'b1,32'h11090004,32'h0040_0100,16'h0004,1'b1,1'b0,5'd0,1'b0,18'h00010});
        apply("rs_rst",   '{1'b1,1'b1,1'b0,1'b1,32'h2008FFFF,32'h0040_0104,1'b0,32'h00000000,32'h00000000,16'h0000,1'b0,1'b0,5'd0,1'b0,18'h0});
        apply("rs_after", '{1'b0,1'b0,1'b0,1'b1,32'h35088000,32'h0040_0108,1'b1,32'h35088000,32'h0040_0108,16'h8000,1'b0,1'b1,5'd0,1'b0,18'h0});
        // Stall holding an illegal instruction keeps illegal and id_valid high.
        apply("st_ill0",  '{1'b0,1'b0,1'b0,1'b1,32'hFC000000,32'h0040_010C,1'b1,32'hFC000000,32'h0040_010C,16'h0000,1'b0,1'b0,5'd0,1'b1,18'h0});
        apply("st_ill1",  '{1'b0,1'b1,1'b0,1'b0,32'h00000000,32'h0040_0110,1'b1,32'hFC000000,32'h0040_010C,16'h0000,1'b0,1'b0,5'd0,1'b1,18'h0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
